// File: rtl/serial_paralelo_sync_pkg.sv
// -----------------------------------------------------------------------------
// serial_paralelo_pkg
// Shared definitions for the serial_paralelo_sync deserializer:
//   - lock FSM state encoding (HUNT / CHECK / LOCKED, 2'd3 unused)
//   - default comma character and default lock / loss counts
// -----------------------------------------------------------------------------
package serial_paralelo_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2,
    UNUSED = 2'd3
  } lock_state_t;

  localparam logic [7:0] COMMA_DEFAULT      = 8'hBC;
  localparam int         LOCK_COUNT_DEFAULT = 4;
  localparam int         LOSS_COUNT_DEFAULT = 2;

endpackage

// File: rtl/serial_paralelo_sync_shift_detect.sv
// -----------------------------------------------------------------------------
// serial_shift_detect
// WIDTH-bit MSB-first shift register plus comma comparator. The comparator
// looks at the value the register is about to take (sr_next), so a comma is
// reported on the same edge that shifts in its last bit.
//
// Ports:
//   clk_32f    in   bit-rate clock
//   reset      in   synchronous, active-high
//   serial_in  in   serial data, one bit per clk_32f
//   sr_next    out  {sr[WIDTH-2:0], serial_in} (combinational)
//   comma_hit  out  sr_next == COMMA (combinational)
// -----------------------------------------------------------------------------
module serial_shift_detect
  import serial_paralelo_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(COMMA_DEFAULT)
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] sr_next,
  output logic             comma_hit
);

  logic [WIDTH-1:0] sr;

  assign sr_next   = {sr[WIDTH-2:0], serial_in};
  assign comma_hit = (sr_next == COMMA);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_32f) begin
    if (reset) sr <= '0;
    else       sr <= sr_next;
  end

endmodule

// File: rtl/serial_paralelo_sync.sv
// -----------------------------------------------------------------------------
// serial_paralelo_sync
// Serial-to-parallel deserializer with comma alignment at any bit offset.
// HUNT looks for a comma anywhere and re-phases the word counter on it;
// CHECK requires LOCK_COUNT consecutive commas on that phase; LOCKED emits
// data words (valid_out) and flags idle commas (comma_out).
//
// Optional build macro RELOCK_EN: while LOCKED, commas seen off the word
// boundary are counted; LOSS_COUNT of them (without an aligned comma in
// between) drop back to HUNT. Without it, LOCKED is left only by reset.
//
// Ports:
//   clk_32f     in   bit-rate clock, all logic on posedge
//   reset       in   synchronous, active-high, highest priority
//   serial_in   in   serial data, MSB first
//   data_out    out  last completed non-comma word while locked
//   valid_out   out  one-cycle pulse, data_out carries a new word
//   comma_out   out  one-cycle pulse, aligned comma received while locked
//   active_out  out  high while LOCKED
//   lock_state  out  FSM state (debug)
// -----------------------------------------------------------------------------
module serial_paralelo_sync
  import serial_paralelo_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(COMMA_DEFAULT),
  parameter int               LOCK_COUNT = LOCK_COUNT_DEFAULT,
  parameter int               LOSS_COUNT = LOSS_COUNT_DEFAULT
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             comma_out,
  output logic             active_out,
  output logic [1:0]       lock_state
);

  localparam int             CW   = $clog2(WIDTH);
  localparam int             KW   = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  if (WIDTH < 4)      begin : g_bad_width $error("WIDTH must be >= 4");      end
  if (LOCK_COUNT < 1) begin : g_bad_lock  $error("LOCK_COUNT must be >= 1"); end
  if (LOSS_COUNT < 1) begin : g_bad_loss  $error("LOSS_COUNT must be >= 1"); end

  logic [WIDTH-1:0] sr_next;
  logic             comma_hit;
  logic [CW-1:0]    bit_cnt;
  logic [KW-1:0]    comma_cnt;
  lock_state_t      state;
  logic             boundary;

`ifdef RELOCK_EN
  localparam int    MW = $clog2(LOSS_COUNT + 1);
  logic [MW-1:0]    misalign_cnt;
`endif

  serial_shift_detect #(
    .WIDTH (WIDTH),
    .COMMA (COMMA)
  ) u_shift_detect (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .serial_in (serial_in),
    .sr_next   (sr_next),
    .comma_hit (comma_hit)
  );

  assign boundary   = (bit_cnt == LAST);
  assign lock_state = state;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      comma_cnt  <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      comma_out  <= 1'b0;
      active_out <= 1'b0;
`ifdef RELOCK_EN
      misalign_cnt <= '0;
`endif
    end else begin
      // Pulses default low; free-running word phase unless re-phased below.
      valid_out <= 1'b0;
      comma_out <= 1'b0;
      bit_cnt   <= boundary ? '0 : bit_cnt + 1'b1;

      case (state)
        HUNT: begin
          // A comma at any offset defines the word phase: next bit is bit 0.
          if (comma_hit) begin
            bit_cnt   <= '0;
            comma_cnt <= KW'(1);
            if (LOCK_COUNT == 1) begin
              state      <= LOCKED;
              active_out <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (boundary) begin
            if (comma_hit) begin
              comma_cnt <= comma_cnt + 1'b1;
              if (comma_cnt == KW'(LOCK_COUNT - 1)) begin
                state      <= LOCKED;
                active_out <= 1'b1;
              end
            end else begin
              state     <= HUNT;
              comma_cnt <= '0;
            end
          end
        end

        LOCKED: begin
          if (boundary) begin
            if (comma_hit) begin
              comma_out <= 1'b1;
`ifdef RELOCK_EN
              misalign_cnt <= '0;
`endif
            end else begin
              data_out  <= sr_next;
              valid_out <= 1'b1;
            end
          end
`ifdef RELOCK_EN
          else if (comma_hit) begin
            // The comma that causes the drop does not re-phase; HUNT
            // starts looking from the next bit.
            if (misalign_cnt == MW'(LOSS_COUNT - 1)) begin
              state        <= HUNT;
              active_out   <= 1'b0;
              misalign_cnt <= '0;
              comma_cnt    <= '0;
            end else begin
              misalign_cnt <= misalign_cnt + 1'b1;
            end
          end
`endif
        end

        default: begin
          state      <= HUNT;
          active_out <= 1'b0;
          comma_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// -----------------------------------------------------------------------------
// tb_serial_paralelo_sync
// Scoreboard bench: the driver feeds bits and advances a bit-stream reference
// model, pushing the expected per-cycle status and expected word/comma events
// into queues; an independent monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_serial_paralelo_sync;

  localparam int         W    = 8;
  localparam logic [7:0] CMA  = 8'hBC;
  localparam int         LOCK = 4;
  localparam int         LOSS = 2;

  logic         clk_32f = 1'b0;
  logic         reset;
  logic         serial_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         comma_out;
  logic         active_out;
  logic [1:0]   lock_state;

  serial_paralelo_sync #(
    .WIDTH      (W),
    .COMMA      (CMA),
    .LOCK_COUNT (LOCK),
    .LOSS_COUNT (LOSS)
  ) dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .comma_out  (comma_out),
    .active_out (active_out),
    .lock_state (lock_state)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct packed {
    logic       valid;
    logic       comma;
    logic       active;
    logic [1:0] state;
    logic [7:0] data;
  } status_t;

  typedef struct packed {
    logic       is_comma;
    logic [7:0] data;
  } event_t;

  status_t st_q[$];
  event_t  ev_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (bit-stream level) ----------------
  // Word phase is expressed as distance from an anchor bit index rather than
  // a counter: a bit completes a word when (t - anchor) % W == W-1.
`ifdef RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  int   m_mode   = 0;   // 0 hunt, 1 check, 2 locked
  int   m_win    = 0;   // last W bits as an integer
  int   m_t      = 0;   // index of next non-reset bit
  int   m_anchor = 0;
  int   m_commas = 0;
  int   m_misses = 0;
  int   m_data   = 0;

  task automatic model_step(input bit b, input bit rst);
    status_t s;
    bit      hit, bnd, v, c;
    v = 0;
    c = 0;
    if (rst) begin
      m_mode   = 0;
      m_win    = 0;
      m_anchor = m_t;
      m_commas = 0;
      m_misses = 0;
      m_data   = 0;
    end else begin
      m_win = (m_win * 2 + int'(b)) % (1 << W);
      hit   = (m_win == int'(CMA));
      bnd   = ((m_t - m_anchor) % W) == W - 1;
      if (m_mode == 0) begin
        if (hit) begin
          m_anchor = m_t + 1;
          m_commas = 1;
          m_mode   = (LOCK == 1) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (bnd) begin
          if (hit) begin
            m_commas++;
            if (m_commas == LOCK) m_mode = 2;
          end else begin
            m_mode   = 0;
            m_commas = 0;
          end
        end
      end else begin
        if (bnd) begin
          if (hit) begin
            c = 1;
            m_misses = 0;
          end else begin
            v = 1;
            m_data = m_win;
          end
        end else if (RELOCK && hit) begin
          m_misses++;
          if (m_misses == LOSS) begin
            m_mode   = 0;
            m_misses = 0;
            m_commas = 0;
          end
        end
      end
      m_t++;
    end
    s.valid  = v;
    s.comma  = c;
    s.active = (m_mode == 2);
    s.state  = 2'(m_mode);
    s.data   = 8'(m_data);
    st_q.push_back(s);
    if (v || c) ev_q.push_back('{is_comma: c, data: 8'(m_data)});
  endtask

  // ---------------- driver ----------------
  task automatic drive_bit(input bit b, input bit rst);
    @(negedge clk_32f);
    serial_in = b;
    reset     = rst;
    model_step(b, rst);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive_bit(v[i], 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'($urandom_range(0, 1)), 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    status_t s;
    event_t  e;
    forever begin
      @(posedge clk_32f);
      #1;
      if (st_q.size() > 0) begin
        s = st_q.pop_front();
        check("valid_out",  32'(valid_out),  32'(s.valid));
        check("comma_out",  32'(comma_out),  32'(s.comma));
        check("active_out", 32'(active_out), 32'(s.active));
        check("lock_state", 32'(lock_state), 32'(s.state));
        check("data_out",   32'(data_out),   32'(s.data));
      end
      if (valid_out === 1'b1 || comma_out === 1'b1) begin
        if (ev_q.size() == 0) begin
          check("pulse_expected", 32'(ev_q.size()), 32'd1);
        end else begin
          e = ev_q.pop_front();
          check("pulse_kind", 32'(comma_out), 32'(e.is_comma));
          if (!e.is_comma) check("word_data", 32'(data_out), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : driver
    reset     = 1'b1;
    serial_in = 1'b0;

    // Reset with random data on the line.
    do_reset(3);

    // Junk bits, four commas to lock, then a data word.
    drive_bit(1, 0); drive_bit(0, 0); drive_bit(1, 0);
    repeat (4) send_byte(8'hBC);
    send_byte(8'hA5);

    // Three commas then data: falls back to HUNT without locking.
    do_reset(2);
    repeat (3) send_byte(8'hBC);
    send_byte(8'h55);

    // Lock, then interleave idle commas and data.
    repeat (4) send_byte(8'hBC);
    send_byte(8'hBC); send_byte(8'h12); send_byte(8'hBC); send_byte(8'h34);

    // Slip one bit, two misaligned commas, then four commas on the new phase.
    drive_bit(1, 0);
    repeat (2) send_byte(8'hBC);
    repeat (4) send_byte(8'hBC);
    send_byte(8'h3C);

    // Reset in the middle of word 77.
    for (int i = 7; i >= 4; i--) drive_bit(8'h77 >> i, 0);
    drive_bit(0, 1);
    for (int i = 3; i >= 0; i--) drive_bit(8'h77 >> i, 0);
    repeat (2) send_byte(8'h00);

    // Randomized traffic: lock, mixed words and commas, occasional slips.
    for (int r = 0; r < 8; r++) begin
      do_reset(1 + $urandom_range(0, 2));
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) drive_bit(1'($urandom_range(0, 1)), 0);
      repeat (LOCK) send_byte(8'hBC);
      for (int k = 0; k < 40; k++) begin
        if ($urandom_range(0, 9) == 0)
          for (int j = 0; j < int'($urandom_range(1, 3)); j++) drive_bit(1'($urandom_range(0, 1)), 0);
        if ($urandom_range(0, 3) == 0) send_byte(8'hBC);
        else                           send_byte(8'($urandom));
      end
    end

    // Pure random bit stream without reset.
    for (int i = 0; i < 400; i++) drive_bit(1'($urandom_range(0, 1)), 0);

    drive_bit(0, 0);
    @(posedge clk_32f);
    #2;
    check("status_queue_drained", 32'(st_q.size()), 32'd0);
    check("event_queue_drained",  32'(ev_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
